spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 4..255.
REQ-002 SHALL have port clk, input, 1: system clock; all state updates on posedge clk.
REQ-003 SHALL have port ar, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request one byte transfer; sampled only while ready=1.
REQ-005 SHALL have port tx_data, input, 8: byte to transmit, captured when the start is accepted.
REQ-006 SHALL have port last, input, 1: captured with the start; 1 = release cs after this byte.
REQ-007 SHALL have port ready, output, 1: block can accept a start this cycle.
REQ-008 SHALL have port rx_data, output, 8: byte received on miso.
REQ-009 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-010 SHALL have port sck, output, 1: SPI clock, idle low (CPOL=0).
REQ-011 SHALL have port mosi, output, 1: SPI data out, MSB first.
REQ-012 SHALL have port miso, input, 1: SPI data in, sampled on SCK rising edge (CPHA=0).
REQ-013 SHALL have port cs, output, 1: chip select, active low.

Function
REQ-014 SHALL implement states IDLE, SETUP, LOW, HIGH, WAIT, HOLD and GAP.
REQ-015 In IDLE and WAIT, ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 In IDLE with start=1, the block SHALL capture tx_data and last, drive cs=0 and mosi=tx_data[7] on the next cycle, and enter SETUP.
REQ-017 SETUP SHALL last CLK_DIV cycles with sck=0, then enter LOW.
REQ-018 LOW and HIGH SHALL each last CLK_DIV cycles, with sck=0 in LOW and sck=1 in HIGH; a 3-bit bit counter SHALL count 8 LOW/HIGH pairs.
REQ-019 On entry to HIGH (sck rising), the block SHALL shift miso into the LSB of an internal receive shift register.
REQ-020 On each HIGH-to-LOW transition (sck falling), mosi SHALL advance to the next lower bit of the captured byte.
REQ-021 After the 8th HIGH, sck SHALL fall, rx_data SHALL load the full shift register, rx_valid SHALL pulse for 1 cycle, and mosi SHALL hold its last bit.
REQ-022 After the 8th HIGH with last=0, the block SHALL enter WAIT with cs=0 and sck=0.
REQ-023 After the 8th HIGH with last=1, the block SHALL enter HOLD.
REQ-024 In WAIT with start=1, the block SHALL capture tx_data and last, set mosi=tx_data[7], and enter LOW directly, skipping SETUP.
REQ-025 In WAIT, the block SHALL keep cs low for as long as start stays low; no timeout.
REQ-026 HOLD SHALL last CLK_DIV cycles with cs=0, then drive cs=1 and enter GAP.
REQ-027 GAP SHALL last CLK_DIV cycles with cs=1, then enter IDLE.
REQ-028 start in any state other than IDLE or WAIT SHALL be ignored, with no queuing.
REQ-029 The half-period counter SHALL be wide enough for 255 and SHALL reload on every state transition.
REQ-030 Timing from the cs-fall cycle SHALL be:
- first sck rise at 2*CLK_DIV cycles;
- 8th sck fall and rx_valid at 17*CLK_DIV cycles;
- cs rise at 18*CLK_DIV cycles (last=1);
- ready at 19*CLK_DIV cycles (last=1).
REQ-031 sck, mosi and cs SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-032 While ar=1, the block SHALL hold state=IDLE, cs=1, sck=0, mosi=0, rx_data=0x00, rx_valid=0, ready=1, and all counters at 0.
REQ-033 Assertion of ar mid-transfer SHALL immediately force cs=1 and sck=0, with no partial rx_valid.
REQ-034 After ar deasserts, the first accepted start SHALL behave exactly per REQ-016.

Verification
REQ-035 Single byte (CLK_DIV=4): start with tx_data=0xA5, last=1, SPI slave model returning 0x3C -> mosi bits 1,0,1,0,0,1,0,1 at the 8 sck rises, rx_data=0x3C, rx_valid at cs-fall+68, cs rise at +72, ready at +76.
REQ-036 Two-byte burst: 0x12 (last=0) then 0x34 (last=1) started in WAIT -> cs stays low throughout, 16 sck pulses, two rx_valid pulses, no SETUP before the second byte.
REQ-037 Busy ignore: pulse start with 0xFF during the LOW of bit 3 of a 0x00 transfer -> mosi stays 0 for all 8 bits and no extra transfer follows.
REQ-038 Reset mid-transfer: assert ar after the 4th sck rise -> cs=1 and sck=0 in the same cycle, no rx_valid; a subsequent 0x5A transfer completes correctly.
REQ-039 Loopback with CLK_DIV=255: tie miso to mosi and send 0xC3 -> rx_data=0xC3, with each sck half-period measured at exactly 255 clk.

Source files
------------

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one byte per start.
// Ports: clk, ar (async reset), start/tx_data/last in; ready, rx_data,
// rx_valid out; sck, mosi, cs (active low) to the bus; miso from the bus.
module spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       ar,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       last,
   output logic       ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic       cs
);

   typedef enum logic [2:0] {
      IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GAP
   } state_t;

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] bcnt_q, bcnt_d;
   logic [7:0] txsr_q, txsr_d;
   logic [7:0] rxsr_q, rxsr_d;
   logic       last_q, last_d;
   logic [7:0] rx_data_d;
   logic       rx_valid_d;
   logic       sck_d, mosi_d, cs_d;
   logic       done;

   assign done  = (cnt_q == DIV_M1);
   assign ready = (state_q == IDLE) || (state_q == WAIT);

   always_ff @(posedge clk or posedge ar) begin
      if (ar) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         bcnt_q   <= 3'd0;
         txsr_q   <= 8'd0;
         rxsr_q   <= 8'd0;
         last_q   <= 1'b0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         cs       <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bcnt_q   <= bcnt_d;
         txsr_q   <= txsr_d;
         rxsr_q   <= rxsr_d;
         last_q   <= last_d;
         rx_data  <= rx_data_d;
         rx_valid <= rx_valid_d;
         sck      <= sck_d;
         mosi     <= mosi_d;
         cs       <= cs_d;
      end
   end

   // Half-period counter restarts from zero on every state change.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 8'd1;
      bcnt_d     = bcnt_q;
      txsr_d     = txsr_q;
      rxsr_d     = rxsr_q;
      last_d     = last_q;
      rx_data_d  = rx_data;
      rx_valid_d = 1'b0;
      sck_d      = sck;
      mosi_d     = mosi;
      cs_d       = cs;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (start) begin
               txsr_d  = tx_data;
               last_d  = last;
               mosi_d  = tx_data[7];
               cs_d    = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (done) begin
               cnt_d   = 8'd0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (done) begin
               cnt_d   = 8'd0;
               sck_d   = 1'b1;
               rxsr_d  = {rxsr_q[6:0], miso};
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (done) begin
               cnt_d = 8'd0;
               sck_d = 1'b0;
               if (bcnt_q == 3'd7) begin
                  bcnt_d     = 3'd0;
                  rx_data_d  = rxsr_q;
                  rx_valid_d = 1'b1;
                  state_d    = last_q ? HOLD : WAIT;
               end else begin
                  bcnt_d  = bcnt_q + 3'd1;
                  mosi_d  = txsr_q[6];
                  txsr_d  = {txsr_q[6:0], 1'b0};
                  state_d = LOW;
               end
            end
         end
         WAIT: begin
            cnt_d = 8'd0;
            // Back-to-back byte: cs already low, go straight to LOW.
            if (start) begin
               txsr_d  = tx_data;
               last_d  = last;
               mosi_d  = tx_data[7];
               state_d = LOW;
            end
         end
         HOLD: begin
            if (done) begin
               cnt_d   = 8'd0;
               cs_d    = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            if (done) begin
               cnt_d   = 8'd0;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = 8'd0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: single byte, burst, busy ignore,
// mid-transfer reset, and CLK_DIV=255 loopback with period measurement.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       ar = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic       last = 1'b0;
   logic       ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       sck, mosi, miso, cs;

   logic       start2 = 1'b0;
   logic [7:0] tx_data2 = 8'd0;
   logic       last2 = 1'b0;
   logic       ready2;
   logic [7:0] rx_data2;
   logic       rx_valid2;
   logic       sck2, mosi2, miso2, cs2;

   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(4)) dut (
      .clk(clk), .ar(ar), .start(start), .tx_data(tx_data),
      .last(last), .ready(ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .sck(sck), .mosi(mosi), .miso(miso),
      .cs(cs)
   );

   spi_master #(.CLK_DIV(255)) dut2 (
      .clk(clk), .ar(ar), .start(start2), .tx_data(tx_data2),
      .last(last2), .ready(ready2), .rx_data(rx_data2),
      .rx_valid(rx_valid2), .sck(sck2), .mosi(mosi2), .miso(miso2),
      .cs(cs2)
   );

   // Slave for dut: presents bit 7 at cs fall, next bit after each sck fall.
   logic [7:0] slv_byte = 8'd0;
   int         nfall = 0;
   logic [2:0] sidx;
   assign sidx = 3'd7 - nfall[2:0];
   assign miso = slv_byte[sidx];

   assign miso2 = mosi2;

   logic       sck_p = 1'b0;
   logic       cs_p = 1'b1;
   logic [7:0] mosi_cap = 8'd0;
   int         nrise = 0;
   int         nvalid = 0;
   int         ncsrise = 0;

   always @(posedge clk) begin
      sck_p <= sck;
      cs_p  <= cs;
      if (cs === 1'b1)
         nfall <= 0;
      else if (sck_p && !sck)
         nfall <= nfall + 1;
      if (!sck_p && sck) begin
         mosi_cap <= {mosi_cap[6:0], mosi};
         nrise    <= nrise + 1;
      end
      if (rx_valid === 1'b1)
         nvalid <= nvalid + 1;
      if (!cs_p && cs)
         ncsrise <= ncsrise + 1;
   end

   // Half-period measurement on dut2's sck.
   logic sck2_p = 1'b0;
   logic seen2 = 1'b0;
   int   since2 = 0;
   int   ntog2 = 0;
   int   hp_min = 100000;
   int   hp_max = 0;

   always @(posedge clk) begin
      sck2_p <= sck2;
      if (sck2_p != sck2) begin
         if (seen2) begin
            if (since2 < hp_min) hp_min <= since2;
            if (since2 > hp_max) hp_max <= since2;
         end
         seen2  <= 1'b1;
         ntog2  <= ntog2 + 1;
         since2 <= 1;
      end else begin
         since2 <= since2 + 1;
      end
   end

   int nchk = 0;
   int nerr = 0;
   int cyc = 0;
   int base_r, base_v, base_c;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at(input int c);
      if (c > cyc) adv(c - cyc);
      cyc = c;
   endtask

   // Cycle 0 is the first cycle with cs low (or LOW, from WAIT).
   task automatic go1(input logic [7:0] d, input logic l);
      tx_data = d;
      last    = l;
      start   = 1'b1;
      adv(1);
      start = 1'b0;
      cyc   = 0;
   endtask

   initial begin
      #2 ar = 1'b1;
      adv(3);
      chk("rst_cs", {31'd0, cs}, 1);
      chk("rst_sck", {31'd0, sck}, 0);
      chk("rst_mosi", {31'd0, mosi}, 0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("rst_rx_valid", {31'd0, rx_valid}, 0);
      chk("rst_ready", {31'd0, ready}, 1);
      ar = 1'b0;
      adv(2);

      // Single byte 0xA5, slave returns 0x3C.
      slv_byte = 8'h3C;
      base_r = nrise; base_v = nvalid;
      go1(8'hA5, 1'b1);
      chk("t1_cs_fall", {31'd0, cs}, 0);
      chk("t1_mosi0", {31'd0, mosi}, 1);
      chk("t1_busy", {31'd0, ready}, 0);
      at(7);
      chk("t1_sck_pre", {31'd0, sck}, 0);
      at(8);
      chk("t1_sck_rise", {31'd0, sck}, 1);
      at(67);
      chk("t1_rxv_early", {31'd0, rx_valid}, 0);
      at(68);
      chk("t1_rxv", {31'd0, rx_valid}, 1);
      chk("t1_rx_data", {24'd0, rx_data}, 32'h3C);
      chk("t1_sck_fall", {31'd0, sck}, 0);
      chk("t1_hold_busy", {31'd0, ready}, 0);
      at(69);
      chk("t1_rxv_pulse", {31'd0, rx_valid}, 0);
      at(71);
      chk("t1_cs_hold", {31'd0, cs}, 0);
      at(72);
      chk("t1_cs_rise", {31'd0, cs}, 1);
      at(75);
      chk("t1_gap_busy", {31'd0, ready}, 0);
      at(76);
      chk("t1_ready", {31'd0, ready}, 1);
      chk("t1_mosi_bits", {24'd0, mosi_cap}, 32'hA5);
      chk("t1_nrise", nrise - base_r, 8);
      chk("t1_nvalid", nvalid - base_v, 1);
      adv(3);

      // Burst 0x12 (last=0) then 0x34 (last=1) from WAIT.
      slv_byte = 8'hA7;
      base_r = nrise; base_v = nvalid; base_c = ncsrise;
      go1(8'h12, 1'b0);
      at(68);
      chk("t2_rxv1", {31'd0, rx_valid}, 1);
      chk("t2_rx1", {24'd0, rx_data}, 32'hA7);
      chk("t2_wait_ready", {31'd0, ready}, 1);
      chk("t2_wait_cs", {31'd0, cs}, 0);
      chk("t2_wait_sck", {31'd0, sck}, 0);
      chk("t2_mosi_b1", {24'd0, mosi_cap}, 32'h12);
      slv_byte = 8'h5E;
      tx_data = 8'h34; last = 1'b1; start = 1'b1;
      at(69);
      start = 1'b0;
      chk("t2_b2_busy", {31'd0, ready}, 0);
      chk("t2_b2_mosi0", {31'd0, mosi}, 0);
      at(72);
      chk("t2_b2_low", {31'd0, sck}, 0);
      at(73);
      chk("t2_no_setup", {31'd0, sck}, 1);
      at(133);
      chk("t2_rxv2", {31'd0, rx_valid}, 1);
      chk("t2_rx2", {24'd0, rx_data}, 32'h5E);
      chk("t2_cs_low", ncsrise - base_c, 0);
      at(137);
      chk("t2_cs_rise", {31'd0, cs}, 1);
      at(141);
      chk("t2_ready", {31'd0, ready}, 1);
      chk("t2_nrise", nrise - base_r, 16);
      chk("t2_nvalid", nvalid - base_v, 2);
      chk("t2_mosi_b2", {24'd0, mosi_cap}, 32'h34);
      adv(3);

      // Busy ignore: start 0xFF during LOW of bit 3 of a 0x00 byte.
      slv_byte = 8'h00;
      base_r = nrise; base_v = nvalid;
      go1(8'h00, 1'b1);
      at(29);
      tx_data = 8'hFF; start = 1'b1;
      at(30);
      start = 1'b0;
      at(76);
      chk("t3_ready", {31'd0, ready}, 1);
      at(120);
      chk("t3_mosi_bits", {24'd0, mosi_cap}, 32'h00);
      chk("t3_nrise", nrise - base_r, 8);
      chk("t3_nvalid", nvalid - base_v, 1);
      chk("t3_idle_cs", {31'd0, cs}, 1);

      // Reset after the 4th sck rise.
      slv_byte = 8'hFF;
      base_v = nvalid;
      go1(8'h96, 1'b1);
      at(33);
      chk("t4_pre_sck", {31'd0, sck}, 1);
      ar = 1'b1;
      #1;
      chk("t4_cs", {31'd0, cs}, 1);
      chk("t4_sck", {31'd0, sck}, 0);
      chk("t4_ready", {31'd0, ready}, 1);
      chk("t4_rxv", {31'd0, rx_valid}, 0);
      adv(3);
      ar = 1'b0;
      adv(80);
      chk("t4_no_rxv", nvalid - base_v, 0);
      chk("t4_rx_data", {24'd0, rx_data}, 32'h00);
      slv_byte = 8'hC6;
      go1(8'h5A, 1'b1);
      chk("t4_cs_fall", {31'd0, cs}, 0);
      chk("t4_mosi0", {31'd0, mosi}, 0);
      at(68);
      chk("t4_rxv2", {31'd0, rx_valid}, 1);
      chk("t4_rx2", {24'd0, rx_data}, 32'hC6);
      at(72);
      chk("t4_cs_rise", {31'd0, cs}, 1);
      chk("t4_mosi_bits", {24'd0, mosi_cap}, 32'h5A);
      at(76);
      chk("t4_ready2", {31'd0, ready}, 1);

      // Loopback on dut2 with CLK_DIV=255.
      tx_data2 = 8'hC3; last2 = 1'b1; start2 = 1'b1;
      adv(1);
      start2 = 1'b0;
      cyc = 0;
      chk("t5_cs_fall", {31'd0, cs2}, 0);
      at(509);
      chk("t5_sck_pre", {31'd0, sck2}, 0);
      at(510);
      chk("t5_sck_rise", {31'd0, sck2}, 1);
      at(4335);
      chk("t5_rxv", {31'd0, rx_valid2}, 1);
      chk("t5_rx_data", {24'd0, rx_data2}, 32'hC3);
      at(4589);
      chk("t5_cs_hold", {31'd0, cs2}, 0);
      at(4590);
      chk("t5_cs_rise", {31'd0, cs2}, 1);
      at(4844);
      chk("t5_gap_busy", {31'd0, ready2}, 0);
      at(4845);
      chk("t5_ready", {31'd0, ready2}, 1);
      chk("t5_ntog", ntog2, 16);
      chk("t5_hp_min", hp_min, 255);
      chk("t5_hp_max", hp_max, 255);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
